// File: rtl/multicycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM sequencer for the MIPS8 core.
// Turns latched opcodes into single-cycle datapath strobes and PC updates.
module multicycle_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  output logic             imem_req,
  input  logic             imem_ack,
  input  logic [4:0]       instr_opcode,
  output logic             dmem_req,
  input  logic             dmem_ack,
  input  logic             flag_z,
  input  logic             flag_l,
  input  logic             flag_g,
  input  logic             halt_req,
  output logic [4:0]       ir_opcode,
  output logic             ir_write,
  output logic             reg_we,
  output logic             flags_we,
  output logic             dm_we,
  output logic             pc_inc,
  output logic             pc_load,
  output logic             illegal_op,
  output logic             bus_error,
  output logic [CNT_W-1:0] retired,
  output logic [1:0]       state
);

  localparam logic [1:0] S_FETCH  = 2'd0;
  localparam logic [1:0] S_DECODE = 2'd1;
  localparam logic [1:0] S_EXEC   = 2'd2;
  localparam logic [1:0] S_MEM    = 2'd3;

  localparam logic [4:0] OP_LW   = 5'd7;
  localparam logic [4:0] OP_SW   = 5'd8;
  localparam logic [4:0] OP_JUMP = 5'd17;

  localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

  logic [1:0] next;
  logic [7:0] wait_cnt;
  logic       is_alu;
  logic       is_mov;
  logic       is_cmp;
  logic       is_mem;
  logic       is_ill;
  logic       taken;
  logic       mem_to;
  logic       retire;

  always_comb begin
    is_alu = 1'b0;
    is_mov = 1'b0;
    is_cmp = 1'b0;
    is_mem = 1'b0;
    taken  = 1'b0;
    is_ill = ir_opcode > OP_JUMP;
    case (ir_opcode)
      5'd1, 5'd2, 5'd3, 5'd4,
      5'd5, 5'd10, 5'd11: is_alu = 1'b1;
      5'd6, 5'd9:         is_mov = 1'b1;
      5'd12:              is_cmp = 1'b1;
      OP_LW, OP_SW:       is_mem = 1'b1;
      5'd13:              taken = flag_z;
      5'd14:              taken = !flag_z;
      5'd15:              taken = flag_g;
      5'd16:              taken = flag_l;
      OP_JUMP:            taken = 1'b1;
      default:            taken = 1'b0;
    endcase
  end

  // Every strobe is gated by reset so nothing leaks during the reset cycle.
  always_comb begin
    next       = state;
    imem_req   = 1'b0;
    ir_write   = 1'b0;
    dmem_req   = 1'b0;
    dm_we      = 1'b0;
    reg_we     = 1'b0;
    flags_we   = 1'b0;
    pc_inc     = 1'b0;
    pc_load    = 1'b0;
    illegal_op = 1'b0;
    retire     = 1'b0;
    mem_to     = 1'b0;
    if (!reset) begin
      case (state)
        S_FETCH: begin
          imem_req = !halt_req;
          if (imem_ack && !halt_req) begin
            ir_write = 1'b1;
            next     = S_DECODE;
          end
        end
        S_DECODE: next = S_EXEC;
        S_EXEC: begin
          if (is_mem) begin
            next = S_MEM;
          end else begin
            reg_we     = is_alu || is_mov;
            flags_we   = is_alu || is_cmp;
            pc_load    = taken;
            pc_inc     = !taken;
            illegal_op = is_ill;
            retire     = 1'b1;
            next       = S_FETCH;
          end
        end
        default: begin
          dmem_req = 1'b1;
          dm_we    = ir_opcode == OP_SW;
          mem_to   = !dmem_ack && wait_cnt == TO_LAST;
          if (dmem_ack) begin
            reg_we = ir_opcode == OP_LW;
            pc_inc = 1'b1;
            retire = 1'b1;
            next   = S_FETCH;
          end else if (mem_to) begin
            pc_inc = 1'b1;
            next   = S_FETCH;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_FETCH;
      ir_opcode <= '0;
      retired   <= '0;
      bus_error <= 1'b0;
      wait_cnt  <= '0;
    end else begin
      state <= next;
      if (ir_write) ir_opcode <= instr_opcode;
      if (retire) retired <= retired + CNT_W'(1);
      if (mem_to) bus_error <= 1'b1;
      if (state == S_EXEC) wait_cnt <= '0;
      else if (state == S_MEM && !dmem_ack) wait_cnt <= wait_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Randomized bench for multicycle_sequencer with an instruction-level model.
// Small counter width so retired wrap-around is reachable quickly.
module tb_multicycle_sequencer;

  localparam int TO = 15;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          imem_req;
  logic          imem_ack;
  logic [4:0]    instr_opcode;
  logic          dmem_req;
  logic          dmem_ack;
  logic          flag_z;
  logic          flag_l;
  logic          flag_g;
  logic          halt_req;
  logic [4:0]    ir_opcode;
  logic          ir_write;
  logic          reg_we;
  logic          flags_we;
  logic          dm_we;
  logic          pc_inc;
  logic          pc_load;
  logic          illegal_op;
  logic          bus_error;
  logic [CW-1:0] retired;
  logic [1:0]    state;

  int n_vec = 0;
  int n_err = 0;
  int unsigned m_ret = 0;
  bit m_bus = 1'b0;

  multicycle_sequencer #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_ack(imem_ack),
    .instr_opcode(instr_opcode),
    .dmem_req(dmem_req), .dmem_ack(dmem_ack),
    .flag_z(flag_z), .flag_l(flag_l), .flag_g(flag_g),
    .halt_req(halt_req), .ir_opcode(ir_opcode),
    .ir_write(ir_write), .reg_we(reg_we),
    .flags_we(flags_we), .dm_we(dm_we),
    .pc_inc(pc_inc), .pc_load(pc_load),
    .illegal_op(illegal_op), .bus_error(bus_error),
    .retired(retired), .state(state)
  );

  always #5 clk = ~clk;

  // {imem_req,ir_write,reg_we,flags_we,dm_we,pc_inc,pc_load,illegal_op,dmem_req}
  function automatic logic [8:0] obs();
    return {imem_req, ir_write, reg_we, flags_we, dm_we,
            pc_inc, pc_load, illegal_op, dmem_req};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One whole instruction; ack_at = MEM cycle of ack (-1 never),
  // rst_at = MEM cycle at which reset is forced (-1 never).
  task automatic exec_instr(input logic [4:0] op, input bit z, input bit l,
                            input bit g, input int ack_at, input int rst_at);
    logic [8:0] e;
    bit alu, mv, cmp, mem, tk;
    halt_req = 1'b0;
    imem_ack = 1'b1;
    instr_opcode = op;
    dmem_ack = 1'b0;
    #2;
    e = 9'b110000000;
    n_vec++;
    if ({state, retired, bus_error, obs()} !==
        {2'd0, CW'(m_ret), m_bus, e}) begin
      n_err++;
      $display("FAIL fetch op=%0d: st=%0d ret=%0d be=%b out=%b want ret=%0d be=%b out=%b",
               op, state, retired, bus_error, obs(), CW'(m_ret), m_bus, e);
    end
    step();
    imem_ack = 1'b0;
    instr_opcode = 5'($urandom);
    #2;
    n_vec++;
    if ({state, ir_opcode, obs()} !== {2'd1, op, 9'd0}) begin
      n_err++;
      $display("FAIL decode op=%0d: st=%0d ir=%0d out=%b want st=1 ir=%0d out=0",
               op, state, ir_opcode, obs(), op);
    end
    step();
    flag_z = z;
    flag_l = l;
    flag_g = g;
    alu = op inside {1, 2, 3, 4, 5, 10, 11};
    mv  = op inside {6, 9};
    cmp = op == 12;
    mem = op inside {7, 8};
    tk  = (op == 17) || (op == 13 && z) || (op == 14 && !z) ||
          (op == 15 && g) || (op == 16 && l);
    e = '0;
    e[6] = alu || mv;
    e[5] = alu || cmp;
    e[3] = !mem && !tk;
    e[2] = tk;
    e[1] = op >= 18;
    #2;
    n_vec++;
    if ({state, obs()} !== {2'd2, e}) begin
      n_err++;
      $display("FAIL exec op=%0d zlg=%b%b%b: st=%0d out=%b want st=2 out=%b",
               op, z, l, g, state, obs(), e);
    end
    step();
    if (!mem) begin
      m_ret++;
      return;
    end
    for (int k = 0; k < TO; k++) begin
      if (k == rst_at) begin
        reset = 1'b1;
        dmem_ack = 1'($urandom);
        #2;
        n_vec++;
        if (obs() !== 9'd0) begin
          n_err++;
          $display("FAIL rst_mem_cycle: out=%b want 0", obs());
        end
        step();
        reset = 1'b0;
        dmem_ack = 1'b0;
        m_ret = 0;
        m_bus = 1'b0;
        #2;
        n_vec++;
        if ({state, ir_opcode, retired, bus_error, obs()} !==
            {2'd0, 5'd0, CW'(0), 1'b0, 9'b100000000}) begin
          n_err++;
          $display("FAIL rst_after: st=%0d ir=%0d ret=%0d be=%b out=%b want all 0, imem_req=1",
                   state, ir_opcode, retired, bus_error, obs());
        end
        return;
      end
      dmem_ack = (k == ack_at);
      e = '0;
      e[0] = 1'b1;
      e[4] = op == 8;
      if (k == ack_at) begin
        e[6] = op == 7;
        e[3] = 1'b1;
      end else if (k == TO - 1) begin
        e[3] = 1'b1;
      end
      #2;
      n_vec++;
      if ({state, obs()} !== {2'd3, e}) begin
        n_err++;
        $display("FAIL mem op=%0d k=%0d: st=%0d out=%b want st=3 out=%b",
                 op, k, state, obs(), e);
      end
      step();
      dmem_ack = 1'b0;
      if (k == ack_at) begin
        m_ret++;
        break;
      end
      if (k == TO - 1) m_bus = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    imem_ack = 1'b1;
    instr_opcode = 5'd1;
    dmem_ack = 1'b1;
    halt_req = 1'b0;
    {flag_z, flag_l, flag_g} = 3'b000;
    #2;
    n_vec++;
    if (obs() !== 9'd0) begin
      n_err++;
      $display("FAIL reset_cycle: out=%b want 0", obs());
    end
    step();
    step();
    reset = 1'b0;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    #2;
    n_vec++;
    if ({state, ir_opcode, retired, bus_error} !== {2'd0, 5'd0, CW'(0), 1'b0}) begin
      n_err++;
      $display("FAIL reset_state: st=%0d ir=%0d ret=%0d be=%b want 0",
               state, ir_opcode, retired, bus_error);
    end
    m_ret = 0;
    m_bus = 1'b0;
    step();
  endtask

  task automatic test_alu();
    exec_instr(5'd1, 1'b0, 1'b0, 1'b0, -1, -1);
    for (int i = 0; i < 12; i++)
      exec_instr(5'($urandom_range(0, 12)), 1'($urandom), 1'($urandom),
                 1'($urandom), -1, -1);
  endtask

  task automatic test_jumps();
    for (int op = 13; op <= 17; op++)
      for (int f = 0; f < 2; f++)
        exec_instr(5'(op), f[0], f[0], f[0], -1, -1);
    exec_instr(5'd15, 1'b1, 1'b1, 1'b0, -1, -1);
    exec_instr(5'd16, 1'b1, 1'b0, 1'b1, -1, -1);
  endtask

  task automatic test_mem();
    exec_instr(5'd7, 1'b0, 1'b0, 1'b0, 3, -1);
    exec_instr(5'd8, 1'b0, 1'b0, 1'b0, 0, -1);
    exec_instr(5'd7, 1'b0, 1'b0, 1'b0, TO - 1, -1);
    for (int i = 0; i < 6; i++)
      exec_instr(5'($urandom_range(7, 8)), 1'b0, 1'b0, 1'b0,
                 $urandom_range(0, TO - 1), -1);
  endtask

  task automatic test_timeout();
    exec_instr(5'd8, 1'b0, 1'b0, 1'b0, -1, -1);
    exec_instr(5'd1, 1'b0, 1'b0, 1'b0, -1, -1);
    exec_instr(5'd7, 1'b0, 1'b0, 1'b0, 2, -1);
  endtask

  task automatic test_illegal();
    exec_instr(5'd20, 1'b0, 1'b0, 1'b0, -1, -1);
    for (int i = 0; i < 4; i++)
      exec_instr(5'($urandom_range(18, 31)), 1'b1, 1'b1, 1'b1, -1, -1);
  endtask

  task automatic test_halt();
    halt_req = 1'b1;
    imem_ack = 1'b1;
    instr_opcode = 5'd1;
    for (int i = 0; i < 4; i++) begin
      #2;
      n_vec++;
      if ({state, obs()} !== {2'd0, 9'd0}) begin
        n_err++;
        $display("FAIL halt cyc=%0d: st=%0d out=%b want st=0 out=0",
                 i, state, obs());
      end
      step();
    end
    exec_instr(5'd6, 1'b0, 1'b0, 1'b0, -1, -1);
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 16; i++)
      exec_instr(5'd0, 1'b0, 1'b0, 1'b0, -1, -1);
  endtask

  task automatic test_reset_mid_mem();
    exec_instr(5'd7, 1'b0, 1'b0, 1'b0, -1, 2);
    exec_instr(5'd1, 1'b0, 1'b0, 1'b0, -1, -1);
    exec_instr(5'd8, 1'b0, 1'b0, 1'b0, -1, 0);
    exec_instr(5'd0, 1'b0, 1'b0, 1'b0, -1, -1);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++)
      exec_instr(5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 $urandom_range(0, TO + 2) >= TO ? -1 : $urandom_range(0, TO - 1),
                 -1);
    exec_instr(5'd0, 1'b0, 1'b0, 1'b0, -1, -1);
  endtask

  initial begin
    test_reset();
    test_alu();
    test_jumps();
    test_mem();
    test_timeout();
    test_illegal();
    test_halt();
    test_wrap();
    test_reset_mid_mem();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
